// File: rtl/mem_ctrl_param.sv
// Latency-modelled byte-addressable memory controller with word/half/byte loads and stores.
// Optional alignment checking is enabled by defining MEM_CTRL_ALIGN_CHECK_EN.
module mem_ctrl_param #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    input  logic [1:0]        instr_mode,
    input  logic              unsigned_ld,
    output logic [31:0]       data_out,
    output logic              op_r,
    output logic              busy,
    output logic              fault
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_capture;
    logic             w_last;

    logic             r_we;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_data;
    logic [1:0]       r_mode;
    logic             r_uns;

    logic [7:0]       r_mem [DEPTH_BYTES];
    logic [IDX_W-1:0] w_bidx [4];
    logic [7:0]       w_rb [4];
    logic             w_bad;
    logic [3:0]       w_wmask;
    logic [31:0]      w_load;
    logic             w_ld_upd;

    // Upper address bits alias onto the same storage and are intentionally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^addr[ADDR_W-1:IDX_W];

    // Next-state logic: the counter runs in WAIT and the final count marks completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Access decode: each byte lane wraps independently around the storage.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_bidx[i] = r_idx + IDX_W'(i);
            w_rb[i]   = r_mem[w_bidx[i]];
        end
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        w_bad = (r_mode == MODE_RSVD) ||
                ((r_mode == MODE_HALF) && r_idx[0]) ||
                ((r_mode == MODE_WORD) && (r_idx[1:0] != 2'b00));
`else
        w_bad = 1'b0;
`endif
        w_wmask = 4'h0;
        w_load  = 32'h0;
        case (r_mode)
            MODE_WORD: begin
                w_wmask = 4'hF;
                w_load  = {w_rb[3], w_rb[2], w_rb[1], w_rb[0]};
            end
            MODE_HALF: begin
                w_wmask = 4'h3;
                w_load  = {{16{~r_uns & w_rb[1][7]}}, w_rb[1], w_rb[0]};
            end
            MODE_BYTE: begin
                w_wmask = 4'h1;
                w_load  = {{24{~r_uns & w_rb[0][7]}}, w_rb[0]};
            end
            default: begin
                w_wmask = 4'h0;
                w_load  = 32'h0;
            end
        endcase
        if (w_bad) begin
            w_wmask = 4'h0;
            w_load  = 32'h0;
        end
        if (!r_we) begin
            w_wmask = 4'h0;
        end
        w_ld_upd = w_last && (!r_we || w_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            op_r     <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
            data_out <= 32'h0;
            r_we     <= 1'b0;
            r_idx    <= '0;
            r_data   <= 32'h0;
            r_mode   <= 2'b00;
            r_uns    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            op_r    <= w_last;
            busy    <= (w_state_nxt != S_IDLE);
            fault   <= w_last & w_bad;
            if (w_ld_upd) begin
                data_out <= w_load;
            end
            if (w_capture) begin
                r_we   <= we;
                r_idx  <= addr[IDX_W-1:0];
                r_data <= data_in;
                r_mode <= instr_mode;
                r_uns  <= unsigned_ld;
            end
        end
    end

    // Storage is never cleared; an aborted access never reaches its commit edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_last && w_wmask[i]) begin
                r_mem[w_bidx[i]] <= r_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Directed self-checking bench for mem_ctrl_param (default parameters).
// Expectations follow MEM_CTRL_ALIGN_CHECK_EN when it is defined for the build.
module tb_mem_ctrl_param;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned LATENCY = 4;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [1:0]        instr_mode;
    logic              unsigned_ld;
    logic [31:0]       data_out;
    logic              op_r;
    logic              busy;
    logic              fault;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    mem_ctrl_param #(
        .ADDR_W     (ADDR_W),
        .DEPTH_BYTES(256),
        .LATENCY    (LATENCY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .we         (we),
        .addr       (addr),
        .data_in    (data_in),
        .instr_mode (instr_mode),
        .unsigned_ld(unsigned_ld),
        .data_out   (data_out),
        .op_r       (op_r),
        .busy       (busy),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after op_r has fallen.
    task automatic run_op(input string tag, input logic i_we, input logic [ADDR_W-1:0] i_addr,
                          input logic [31:0] i_data, input logic [1:0] i_mode, input logic i_uns,
                          output logic [31:0] o_dout, output logic o_fault);
        int cyc;
        enable      = 1'b1;
        we          = i_we;
        addr        = i_addr;
        data_in     = i_data;
        instr_mode  = i_mode;
        unsigned_ld = i_uns;
        @(posedge clk);
        #1 enable = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!op_r && cyc < 20);
        check({tag, " latency"}, 32'(cyc), 32'(LATENCY + 1));
        o_dout  = data_out;
        o_fault = fault;
        @(negedge clk);
        check({tag, " idle after"}, {30'h0, op_r, busy}, 32'h0);
    endtask

    logic [31:0] d;
    logic        f;
    int          pulses;

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        we          = 1'b0;
        addr        = '0;
        data_in     = 32'h0;
        instr_mode  = 2'b00;
        unsigned_ld = 1'b0;
        repeat (3) @(negedge clk);
        check("reset data_out", data_out, 32'h0);
        check("reset op_r/busy/fault", {29'h0, op_r, busy, fault}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload bytes 0..3 = 13 82 40 00, then word load
        run_op("preload st", 1'b1, 24'h000000, 32'h00408213, 2'b00, 1'b0, d, f);
        check("store keeps data_out", d, 32'h0);
        check("store fault", 32'(f), 32'h0);
        run_op("word ld 0", 1'b0, 24'h000000, 32'hFFFFFFFF, 2'b00, 1'b0, d, f);
        check("word ld 0 data", d, 32'h00408213);

        // Word store then signed/unsigned byte loads
        run_op("st 0x10", 1'b1, 24'h000010, 32'hAABBCCDD, 2'b00, 1'b0, d, f);
        run_op("lb 0x11", 1'b0, 24'h000011, 32'h0, 2'b01, 1'b0, d, f);
        check("lb 0x11 signed", d, 32'hFFFFFFCC);
        run_op("lbu 0x11", 1'b0, 24'h000011, 32'h0, 2'b01, 1'b1, d, f);
        check("lbu 0x11 unsigned", d, 32'h000000CC);

        // Half store over a known word; upper half must survive
        run_op("st 0x20", 1'b1, 24'h000020, 32'h44332211, 2'b00, 1'b0, d, f);
        run_op("sh 0x20", 1'b1, 24'h000020, 32'h12348001, 2'b10, 1'b0, d, f);
        run_op("lh 0x20", 1'b0, 24'h000020, 32'h0, 2'b10, 1'b0, d, f);
        check("lh 0x20 signed", d, 32'hFFFF8001);
        run_op("lw 0x20", 1'b0, 24'h000020, 32'h0, 2'b00, 1'b0, d, f);
        check("lw 0x20 after sh", d, 32'h44338001);

        // Re-request while busy plus input changes mid-access are both ignored
        enable     = 1'b1;
        we         = 1'b0;
        addr       = 24'h000010;
        instr_mode = 2'b00;
        @(posedge clk);
        #1 enable = 1'b0;
        pulses = 0;
        d      = 32'h0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (op_r) begin
                pulses++;
                d = data_out;
            end
            if (c == 2) begin
                check("busy mid request", 32'(busy), 32'h1);
                enable = 1'b1;
                addr   = 24'h000000;
            end
            if (c == 3) enable = 1'b0;
        end
        check("single op_r pulse", 32'(pulses), 32'h1);
        check("captured addr kept", d, 32'hAABBCCDD);

        // Reset in the middle of a store aborts it
        enable     = 1'b1;
        we         = 1'b1;
        addr       = 24'h000010;
        data_in    = 32'hDEADBEEF;
        instr_mode = 2'b00;
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset data_out", data_out, 32'h0);
        check("mid reset op_r/busy/fault", {29'h0, op_r, busy, fault}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("lw after abort", 1'b0, 24'h000010, 32'h0, 2'b00, 1'b0, d, f);
        check("aborted store no write", d, 32'hAABBCCDD);

        // Misaligned word store at 0x02
        run_op("sw 0x02", 1'b1, 24'h000002, 32'hCAFEF00D, 2'b00, 1'b0, d, f);
        check("sw 0x02 fault", 32'(f), 32'(ALIGN_EN));
        check("sw 0x02 data_out", d, ALIGN_EN ? 32'h0 : 32'hAABBCCDD);
        run_op("lw 0 after sw 0x02", 1'b0, 24'h000000, 32'h0, 2'b00, 1'b0, d, f);
        check("lw 0 after sw 0x02", d, ALIGN_EN ? 32'h00408213 : 32'hF00D8213);

        // Reserved mode: no write, load returns 0
        run_op("st rsvd", 1'b1, 24'h000010, 32'h55555555, 2'b11, 1'b0, d, f);
        check("st rsvd fault", 32'(f), 32'(ALIGN_EN));
        run_op("ld rsvd", 1'b0, 24'h000010, 32'h0, 2'b11, 1'b0, d, f);
        check("ld rsvd data", d, 32'h0);
        check("ld rsvd fault", 32'(f), 32'(ALIGN_EN));
        run_op("lw after st rsvd", 1'b0, 24'h000010, 32'h0, 2'b00, 1'b0, d, f);
        check("rsvd store no write", d, 32'hAABBCCDD);

`ifndef MEM_CTRL_ALIGN_CHECK_EN
        // Word access wrapping past the top of storage
        run_op("sw wrap", 1'b1, 24'h0001FE, 32'h11223344, 2'b00, 1'b0, d, f);
        run_op("lw wrap", 1'b0, 24'h0000FE, 32'h0, 2'b00, 1'b0, d, f);
        check("lw wrap data", d, 32'h11223344);
        run_op("lbu wrap", 1'b0, 24'h000101, 32'h0, 2'b01, 1'b1, d, f);
        check("lbu byte 1 after wrap", d, 32'h00000011);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
